control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/ctrl_decoder.sv | 69 ++++++
 rtl/control_unit.sv | 116 +++++++++++
 tb/tb_control_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, instruction-type and ALU
// codes, FSM states, instruction classes and the branch-condition helper.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] IT_R = 2'b00;
  localparam logic [1:0] IT_I = 2'b01;
  localparam logic [1:0] IT_S = 2'b10;
  localparam logic [1:0] IT_B = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } iclass_t;

  // beq / bne only; every other branch funct3 falls through untaken
  function automatic logic br_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder: im_data -> instType, ALUop, ALUsrc,
// MemtoReg and the instruction class that steers the control FSM.
module ctrl_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [1:0]  o_inst_type,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_mem_to_reg,
  output iclass_t     o_cls
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7_5;
  logic       w_unused_bits;

  assign w_opcode      = i_instr[6:0];
  assign w_funct3      = i_instr[14:12];
  assign w_funct7_5    = i_instr[30];
  assign w_unused_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

  always_comb begin
    o_inst_type  = IT_R;
    o_alu_op     = ALU_ADD;
    o_alu_src    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_cls        = CLS_ILLEGAL;
    case (w_opcode)
      OP_R: begin
        o_cls     = CLS_R;
        o_alu_src = 1'b1;
        case (w_funct3)
          3'b000:  o_alu_op = w_funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  o_alu_op = ALU_AND;
          3'b110:  o_alu_op = ALU_OR;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      OP_I: begin
        o_cls       = CLS_I;
        o_inst_type = IT_I;
        case (w_funct3)
          3'b111:  o_alu_op = ALU_AND;
          3'b110:  o_alu_op = ALU_OR;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      OP_LOAD: begin
        o_cls        = CLS_LOAD;
        o_inst_type  = IT_I;
        o_mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        o_cls       = CLS_STORE;
        o_inst_type = IT_S;
      end
      OP_BRANCH: begin
        o_cls       = CLS_BRANCH;
        o_inst_type = IT_B;
        o_alu_op    = ALU_SUB;
        o_alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM and program counter. Define CTRL_ILLEGAL_TRAP_EN to
// halt on unknown opcodes; otherwise they execute as a 2-cycle NOP.
module control_unit
  import cpu_pkg::*;
#(
  parameter  int IM_L = 16,
  localparam int PCW  = (IM_L > 1) ? $clog2(IM_L) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    im_data,
  input  logic           ALUzero,
  input  logic [PCW-1:0] PCnext,
  output logic [PCW-1:0] PC,
  output logic           RegWrite,
  output logic           ALUsrc,
  output logic           PCsrc,
  output logic           MemtoReg,
  output logic [1:0]     instType,
  output logic [3:0]     ALUop,
  output logic           dm_we,
  output logic           halted
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [PCW-1:0] r_pc;
  logic           w_pc_load;
  logic           w_reg_write;
  logic           w_dm_we;
  logic           w_pc_src;
  logic           w_taken;
  iclass_t        w_cls;

  ctrl_decoder u_dec (
    .i_instr      (im_data),
    .o_inst_type  (instType),
    .o_alu_op     (ALUop),
    .o_alu_src    (ALUsrc),
    .o_mem_to_reg (MemtoReg),
    .o_cls        (w_cls)
  );

  assign w_taken = br_taken(im_data[14:12], ALUzero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  // PC advances only on the edge that retires the instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_pc <= '0;
    else if (w_pc_load) r_pc <= PCnext;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_load   = 1'b0;
    w_reg_write = 1'b0;
    w_dm_we     = 1'b0;
    w_pc_src    = 1'b0;
    case (r_state)
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        case (w_cls)
          CLS_R, CLS_I:        w_state_nxt = S_WB;
          CLS_LOAD, CLS_STORE: w_state_nxt = S_MEM;
          CLS_BRANCH: begin
            w_pc_src    = w_taken;
            w_pc_load   = 1'b1;
            w_state_nxt = S_FETCH;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            w_state_nxt = S_HALT;
`else
            w_pc_load   = 1'b1;
            w_state_nxt = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        if (w_cls == CLS_STORE) begin
          w_dm_we     = 1'b1;
          w_pc_load   = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_pc_load   = 1'b1;
        w_state_nxt = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: w_state_nxt = S_HALT;
`endif
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign PC       = r_pc;
  assign RegWrite = w_reg_write;
  assign dm_we    = w_dm_we;
  assign PCsrc    = w_pc_src;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign halted = (r_state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected strobes/PC are queued
// when an instruction is applied and popped as the FSM walks its states.
module tb_control_unit;

  localparam int IM_L = 16;
  localparam int PCW  = 4;

  typedef struct packed {
    logic           rw;
    logic           we;
    logic           src;
    logic           hlt;
    logic [PCW-1:0] pc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    im_data = 32'h0;
  logic           ALUzero = 1'b0;
  logic [PCW-1:0] PCnext = '0;
  logic [PCW-1:0] PC;
  logic           RegWrite, ALUsrc, PCsrc, MemtoReg, dm_we, halted;
  logic [1:0]     instType;
  logic [3:0]     ALUop;

  int             checks   = 0;
  int             failures = 0;
  exp_t           sbq[$];
  exp_t           obs;
  logic [PCW-1:0] cur_pc;

  control_unit #(.IM_L(IM_L)) dut (
    .clk      (clk),
    .rst      (rst),
    .im_data  (im_data),
    .ALUzero  (ALUzero),
    .PCnext   (PCnext),
    .PC       (PC),
    .RegWrite (RegWrite),
    .ALUsrc   (ALUsrc),
    .PCsrc    (PCsrc),
    .MemtoReg (MemtoReg),
    .instType (instType),
    .ALUop    (ALUop),
    .dm_we    (dm_we),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  assign obs = {RegWrite, dm_we, PCsrc, halted, PC};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic rw, input logic we, input logic src,
                          input logic hlt, input logic [PCW-1:0] pc);
    sbq.push_back({rw, we, src, hlt, pc});
  endtask

  task automatic apply(input logic [31:0] im, input logic z, input logic [PCW-1:0] pcn);
    im_data = im;
    ALUzero = z;
    PCnext  = pcn;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1 checks++;
    if (obs !== exp_t'(0)) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", obs, exp_t'(0));
    end
  endtask

  task automatic test_decode;
    logic [31:0] ims  [11] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                               32'h0020C1B3, 32'h00500293, 32'h0FF07293, 32'h0FF06293,
                               32'h00002283, 32'h00502023, 32'h00000463};
    logic [7:0]  want [11] = '{{2'b00, 4'b0010, 2'b10}, {2'b00, 4'b0110, 2'b10},
                               {2'b00, 4'b0000, 2'b10}, {2'b00, 4'b0001, 2'b10},
                               {2'b00, 4'b0010, 2'b10}, {2'b01, 4'b0010, 2'b00},
                               {2'b01, 4'b0000, 2'b00}, {2'b01, 4'b0001, 2'b00},
                               {2'b01, 4'b0010, 2'b01}, {2'b10, 4'b0010, 2'b00},
                               {2'b11, 4'b0110, 2'b10}};
    for (int i = 0; i < 11; i++) begin
      im_data = ims[i];
      #1 checks++;
      if ({instType, ALUop, ALUsrc, MemtoReg} !== want[i]) begin
        failures++;
        $display("FAIL decode[%0d] im=%h got=%b want=%b", i, ims[i],
                 {instType, ALUop, ALUsrc, MemtoReg}, want[i]);
      end
    end
    im_data = 32'hFFFFFFFF;
    #1 checks++;
    if ({instType, ALUsrc, MemtoReg} !== 4'b0000) begin
      failures++;
      $display("FAIL decode_unknown got=%b want=0000", {instType, ALUsrc, MemtoReg});
    end
  endtask

  task automatic test_rtype;
    exp_t e;
    apply(32'h002081B3, 1'b0, 4'd5);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(1, 0, 0, 0, cur_pc);
    repeat (3) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL rtype_cycle got=%b want=%b", obs, e); end
      @(negedge clk);
    end
    cur_pc = 4'd5;
  endtask

  task automatic test_load;
    exp_t e;
    apply(32'h00002283, 1'b0, cur_pc + 4'd2);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(1, 0, 0, 0, cur_pc);
    repeat (4) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL load_cycle got=%b want=%b", obs, e); end
      @(negedge clk);
    end
    cur_pc = cur_pc + 4'd2;
  endtask

  task automatic test_store;
    exp_t e;
    apply(32'h00502023, 1'b0, cur_pc + 4'd1);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(0, 1, 0, 0, cur_pc);
    repeat (3) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL store_cycle got=%b want=%b", obs, e); end
      @(negedge clk);
    end
    cur_pc = cur_pc + 4'd1;
  endtask

  task automatic test_branch;
    logic [31:0]    ims [5] = '{32'h00000463, 32'h00000463, 32'h00001463,
                                32'h00001463, 32'h00004463};
    logic           zs  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [PCW-1:0] pcs [5] = '{4'd4, 4'd6, 4'd9, 4'd10, 4'd11};
    logic           tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      apply(ims[i], zs[i], pcs[i]);
      push_exp(0, 0, 0, 0, cur_pc);
      push_exp(0, 0, tk[i], 0, cur_pc);
      repeat (2) begin
        #1 e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL branch[%0d] got=%b want=%b", i, obs, e); end
        @(negedge clk);
      end
      cur_pc = pcs[i];
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    apply(32'h00000463, 1'b0, 4'd15);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(0, 0, 0, 0, cur_pc);
    apply_next: begin end
    repeat (2) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL wrap_to_top got=%b want=%b", obs, e); end
      @(negedge clk);
    end
    apply(32'h00000463, 1'b0, 4'd0);
    push_exp(0, 0, 0, 0, 4'd15);
    push_exp(0, 0, 0, 0, 4'd15);
    repeat (2) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL wrap_last got=%b want=%b", obs, e); end
      @(negedge clk);
    end
    cur_pc = 4'd0;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    apply(32'h00500293, 1'b0, 4'd7);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(1, 0, 0, 0, cur_pc);
    apply_store: begin end
    repeat (3) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL rst_mid_pre got=%b want=%b", obs, e); end
      @(negedge clk);
    end
    apply(32'h00502023, 1'b0, 4'd8);
    push_exp(0, 0, 0, 0, 4'd7);
    push_exp(0, 0, 0, 0, 4'd7);
    push_exp(0, 1, 0, 0, 4'd7);
    repeat (3) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL rst_mid_store got=%b want=%b", obs, e); end
      if (sbq.size() != 0) @(negedge clk);
    end
    #1 rst = 1'b1;
    #1 checks++;
    if (obs !== exp_t'(0)) begin
      failures++;
      $display("FAIL rst_mid_abort got=%b want=%b", obs, exp_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    cur_pc = 4'd0;
  endtask

  task automatic test_illegal;
    exp_t e;
    apply(32'hFFFFFFFF, 1'b0, cur_pc + 4'd3);
    push_exp(0, 0, 0, 0, cur_pc);
    push_exp(0, 0, 0, 0, cur_pc);
`ifdef CTRL_ILLEGAL_TRAP_EN
    repeat (4) push_exp(0, 0, 0, 1, cur_pc);
    repeat (6) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL illegal_halt got=%b want=%b", obs, e); end
      @(negedge clk);
    end
    rst = 1'b1;
    #1 checks++;
    if (obs !== exp_t'(0)) begin
      failures++;
      $display("FAIL illegal_reset got=%b want=%b", obs, exp_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    cur_pc = 4'd0;
`else
    repeat (2) begin
      #1 e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL illegal_nop got=%b want=%b", obs, e); end
      @(negedge clk);
    end
    cur_pc = cur_pc + 4'd3;
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0]    ims [4] = '{32'h002081B3, 32'h00002283, 32'h00502023, 32'h00000463};
    int             len [4] = '{3, 4, 3, 2};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      apply(ims[i], 1'b1, cur_pc + 4'd3);
      for (int c = 0; c < len[i]; c++)
        push_exp((i < 2) && (c == len[i] - 1), (i == 2) && (c == 2),
                 (i == 3) && (c == 1), 1'b0, cur_pc);
      repeat (len[i]) begin
        #1 e = sbq.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b[%0d] got=%b want=%b", i, obs, e); end
        @(negedge clk);
      end
      cur_pc = cur_pc + 4'd3;
    end
    push_exp(0, 0, 0, 0, cur_pc);
    #1 e = sbq.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_final_pc got=%b want=%b", obs, e); end
  endtask

  initial begin
    test_reset();
    test_decode();
    @(negedge clk);
    rst = 1'b0;
    cur_pc = 4'd0;
    test_rtype();
    test_load();
    test_store();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
